cms_pix_28_sw_to_fw_decoder: RTL and testbench
==============================================

# cms_pix_28_sw_to_fw_decoder

Upstream command stage for the CMS pixel-28 test firmware. It sits between the software-facing AXI register slice and up to 15 firmware IP instances. It decodes each software write of `sw_write32_0` into a per-IP device enable, one decoded op-code level and a 24-bit payload feed-through. It also returns the selected IP's read data and status to software through registered read muxes, and keeps decoder-level command and error counters.

## Interface
Parameters:
- `NUM_FW`, default 15: number of attached firmware IPs, legal range 1..15.

Ports:
- `fw_clk`  in  1  FW clock.
- `fw_rst`  in  1  asynchronous reset, active-high.
- `sw_write32_0`  in  32  command word: [31:28] dev_id, [27:24] op_code, [23:0] payload.
- `sw_write32_0_wr`  in  1  single-cycle write strobe from the register slice.
- `fw_dev_id_enable`  out  NUM_FW  one-hot; bit i-1 selects dev_id i.
- `fw_op_code_w_reset`, `fw_op_code_w_cfg_static_0`, `fw_op_code_r_cfg_static_0`, `fw_op_code_w_cfg_array_0`, `fw_op_code_r_cfg_array_0`, `fw_op_code_w_cfg_array_1`, `fw_op_code_r_cfg_array_1`, `fw_op_code_r_data_array_0`, `fw_op_code_r_data_array_1`, `fw_op_code_r_status`, `fw_op_code_w_execute`  out  1 each  decoded op-code levels, at most one high at a time.
- `sw_write24_0`  out  24  registered payload.
- `fw_read_data32_all`  in  32*NUM_FW  concatenated `fw_read_data32`; IP i occupies [32*i-1 : 32*(i-1)].
- `fw_read_status32_all`  in  32*NUM_FW  concatenated `fw_read_status32`, same packing.
- `sw_read32_0`  out  32  data read-back.
- `sw_read32_1`  out  32  status read-back.

## Operation
Op-code map:
- 0x0: none.
- 0x1: w_reset.
- 0x2: w_cfg_static_0.
- 0x3: r_cfg_static_0.
- 0x4: w_cfg_array_0.
- 0x5: r_cfg_array_0.
- 0x6: w_cfg_array_1.
- 0x7: r_cfg_array_1.
- 0x8: r_data_array_0.
- 0x9: r_data_array_1.
- 0xA: r_status.
- 0xB: w_execute.
- 0xC–0xE: illegal.
- 0xF: illegal, except as the clear command below.

Decode on every `sw_write32_0_wr`:
- The command register captures dev_id, op_code and payload.
- Outputs are held as levels until the next strobe; there is no auto-clear.
- dev_id in 1..NUM_FW: the enable bit is set and the decoded op-code is driven.
- dev_id 0 or dev_id > NUM_FW: all enables are 0 and all op-codes are 0. The payload is still registered.
- op_code 0x0: all op-code outputs are 0; the enable is still driven.
- Illegal op_code: all op-code outputs are 0, the enable is 0, `illegal_cnt` increments and the sticky `err` bit is set.
- Clear command (dev_id 0 with op_code 0xF): clears `cmd_cnt`, `illegal_cnt` and `err`. It is neither counted nor flagged.
- `cmd_cnt` (16-bit, wrapping) increments on every strobe except the clear command.
- `illegal_cnt` (8-bit) saturates at 0xFF.

Read-back:
- dev_id valid: `sw_read32_0` is the selected IP's data word and `sw_read32_1` is the selected IP's status word.
- dev_id invalid: `sw_read32_0` = {`err`, 7'b0, `illegal_cnt`, `cmd_cnt`} and `sw_read32_1` = 32'h0.

Reset:
- All outputs are 0.
- The command register, `cmd_cnt`, `illegal_cnt` and `err` are 0.

## Timing
- Strobe sampled at edge N → enable, op-code and payload change at edge N+1. Latency is 1 cycle and all are glitch-free register outputs.
- Counters and `err` update at edge N+1, together with the outputs.
- Read path: registered mux with select taken from the registered dev_id.
  - A change on the `_all` inputs at edge M is visible at edge M+1.
  - After a new dev_id, the read-back reflects the new IP at edge N+2.
- Strobes on consecutive cycles are all accepted; each is counted and the last one wins.
- A strobe held high for k cycles counts as k commands. The register slice guarantees single-cycle strobes.
- Reset asserted mid-command: all outputs go to 0 immediately (asynchronous assert). Operation resumes on the first strobe after the synchronous release.
- A strobe on the same edge as reset release is ignored.

## Structure
Package `cms_pix_28_fw_pkg` holds:
- the op-code enum `op_code_t` (4-bit, values above);
- constants `DEV_ID_W=4`, `OP_CODE_W=4`, `PAYLOAD_W=24`;
- the clear-command encoding;
- the packed command struct {dev_id, op_code, payload}.

One sub-module, `cms_pix_28_rd_mux`: the parameterized registered 32-bit N:1 read mux, instantiated twice (data and status).

## Test plan
- Reset, then write 0x2B_00_00_AA → `fw_dev_id_enable` = 15'h0002, `fw_op_code_w_execute` = 1, `sw_write24_0` = 0x0000AA one cycle after the strobe, `cmd_cnt` = 1.
- Each op-code 0x1..0xB to dev 1 → exactly one matching op-code output high, held until the next strobe.
- Write op_code 0xD to dev 3 → enables 0, op-codes 0. Then read with dev_id 0: `sw_read32_0` = 0x8001_0002 (err=1, illegal_cnt=1, cmd_cnt=2).
- Set `fw_read_data32_all` slot 5 = 0xDEADBEEF and status slot 5 = 0x12345678, write dev 5 op 0x8 → `sw_read32_0` = 0xDEADBEEF and `sw_read32_1` = 0x12345678 at strobe+2.
- 300 back-to-back illegal strobes → `illegal_cnt` = 0xFF (saturated), `cmd_cnt` = 300. Clear command 0x0F000000 → both counters 0, `err` = 0.
- Assert reset mid-sequence with dev 7 active → all outputs 0 immediately. After release, dev_id 0 readback = 0x0000_0000.

Source files
------------

// File: rtl/cms_pix_28_fw_pkg.sv
// Shared types and constants for the CMS pixel-28 software-to-firmware command path.
// The command word is {dev_id, op_code, payload} packed MSB first into 32 bits.
package cms_pix_28_fw_pkg;

    localparam int DEV_ID_W  = 4;
    localparam int OP_CODE_W = 4;
    localparam int PAYLOAD_W = 24;
    localparam int NUM_OPS   = 11;

    typedef enum logic [OP_CODE_W-1:0] {
        OP_NONE             = 4'h0,
        OP_W_RESET          = 4'h1,
        OP_W_CFG_STATIC_0   = 4'h2,
        OP_R_CFG_STATIC_0   = 4'h3,
        OP_W_CFG_ARRAY_0    = 4'h4,
        OP_R_CFG_ARRAY_0    = 4'h5,
        OP_W_CFG_ARRAY_1    = 4'h6,
        OP_R_CFG_ARRAY_1    = 4'h7,
        OP_R_DATA_ARRAY_0   = 4'h8,
        OP_R_DATA_ARRAY_1   = 4'h9,
        OP_R_STATUS         = 4'hA,
        OP_W_EXECUTE        = 4'hB,
        OP_CLEAR            = 4'hF
    } op_code_t;

    typedef struct packed {
        logic [DEV_ID_W-1:0]  dev_id;
        op_code_t             op_code;
        logic [PAYLOAD_W-1:0] payload;
    } cmd_t;

    // dev_id 0 paired with op_code 0xF clears the decoder counters
    localparam logic [DEV_ID_W-1:0] CLEAR_DEV_ID  = '0;
    localparam op_code_t            CLEAR_OP_CODE = OP_CLEAR;

    function automatic logic op_is_legal(input op_code_t op);
        return (op <= OP_W_EXECUTE);
    endfunction

endpackage

// File: rtl/cms_pix_28_rd_mux.sv
// Registered N:1 read-back mux; sel 1..NUM picks a slot, anything else returns dflt.
module cms_pix_28_rd_mux
    import cms_pix_28_fw_pkg::*;
#(
    parameter int NUM    = 15,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEV_ID_W-1:0]   sel,
    input  logic [DATA_W*NUM-1:0] data_all,
    input  logic [DATA_W-1:0]     dflt,
    output logic [DATA_W-1:0]     rd_data_p2
);

    logic [DATA_W-1:0] rd_nxt;

    always_comb begin
        rd_nxt = dflt;
        for (int i = 0; i < NUM; i++) begin
            if (sel == DEV_ID_W'(i + 1)) rd_nxt = data_all[DATA_W*i +: DATA_W];
        end
    end

    // stage p2: read-back register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data_p2 <= '0;
        else     rd_data_p2 <= rd_nxt;
    end

endmodule

// File: rtl/cms_pix_28_sw_to_fw_decoder.sv
// Decodes software command writes into per-IP enables and op-code levels, and
// returns the selected IP's data/status (or decoder counters) to software.
module cms_pix_28_sw_to_fw_decoder
    import cms_pix_28_fw_pkg::*;
#(
    parameter int NUM_FW = 15
) (
    input  logic                   fw_clk,
    input  logic                   fw_rst,
    input  logic [31:0]            sw_write32_0,
    input  logic                   sw_write32_0_wr,
    output logic [NUM_FW-1:0]      fw_dev_id_enable,
    output logic                   fw_op_code_w_reset,
    output logic                   fw_op_code_w_cfg_static_0,
    output logic                   fw_op_code_r_cfg_static_0,
    output logic                   fw_op_code_w_cfg_array_0,
    output logic                   fw_op_code_r_cfg_array_0,
    output logic                   fw_op_code_w_cfg_array_1,
    output logic                   fw_op_code_r_cfg_array_1,
    output logic                   fw_op_code_r_data_array_0,
    output logic                   fw_op_code_r_data_array_1,
    output logic                   fw_op_code_r_status,
    output logic                   fw_op_code_w_execute,
    output logic [PAYLOAD_W-1:0]   sw_write24_0,
    input  logic [32*NUM_FW-1:0]   fw_read_data32_all,
    input  logic [32*NUM_FW-1:0]   fw_read_status32_all,
    output logic [31:0]            sw_read32_0,
    output logic [31:0]            sw_read32_1
);

    localparam logic [DEV_ID_W-1:0] MAX_DEV = DEV_ID_W'(NUM_FW);

    cmd_t                  cmd_in;
    logic                  dev_ok;
    logic                  op_ok;
    logic                  is_clear;
    logic                  is_illegal;
    logic [NUM_FW-1:0]     en_nxt;
    logic [NUM_OPS-1:0]    op_nxt;

    logic [DEV_ID_W-1:0]   dev_id_p1;
    logic [PAYLOAD_W-1:0]  payload_p1;
    logic [NUM_OPS-1:0]    op_p1;
    logic [15:0]           cmd_cnt;
    logic [7:0]            illegal_cnt;
    logic                  err;

    assign cmd_in = cmd_t'(sw_write32_0);

    always_comb begin
        dev_ok     = (cmd_in.dev_id != '0) && (cmd_in.dev_id <= MAX_DEV);
        op_ok      = op_is_legal(cmd_in.op_code);
        is_clear   = (cmd_in.dev_id == CLEAR_DEV_ID) && (cmd_in.op_code == CLEAR_OP_CODE);
        is_illegal = !op_ok && !is_clear;
        en_nxt     = '0;
        op_nxt     = '0;
        if (dev_ok && op_ok) begin
            en_nxt = NUM_FW'(1) << (cmd_in.dev_id - DEV_ID_W'(1));
            if (cmd_in.op_code != OP_NONE)
                op_nxt = NUM_OPS'(1) << (4'(cmd_in.op_code) - OP_CODE_W'(1));
        end
    end

    // stage p1: command register, decoded levels and counters
    always_ff @(posedge fw_clk or posedge fw_rst) begin
        if (fw_rst) begin
            dev_id_p1        <= '0;
            payload_p1       <= '0;
            op_p1            <= '0;
            fw_dev_id_enable <= '0;
            cmd_cnt          <= '0;
            illegal_cnt      <= '0;
            err              <= 1'b0;
        end else if (sw_write32_0_wr) begin
            dev_id_p1        <= cmd_in.dev_id;
            payload_p1       <= cmd_in.payload;
            op_p1            <= op_nxt;
            fw_dev_id_enable <= en_nxt;
            if (is_clear) begin
                cmd_cnt     <= '0;
                illegal_cnt <= '0;
                err         <= 1'b0;
            end else begin
                cmd_cnt <= cmd_cnt + 16'd1;
                if (is_illegal) begin
                    if (illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
                    err <= 1'b1;
                end
            end
        end
    end

    assign sw_write24_0              = payload_p1;
    assign fw_op_code_w_reset        = op_p1[0];
    assign fw_op_code_w_cfg_static_0 = op_p1[1];
    assign fw_op_code_r_cfg_static_0 = op_p1[2];
    assign fw_op_code_w_cfg_array_0  = op_p1[3];
    assign fw_op_code_r_cfg_array_0  = op_p1[4];
    assign fw_op_code_w_cfg_array_1  = op_p1[5];
    assign fw_op_code_r_cfg_array_1  = op_p1[6];
    assign fw_op_code_r_data_array_0 = op_p1[7];
    assign fw_op_code_r_data_array_1 = op_p1[8];
    assign fw_op_code_r_status       = op_p1[9];
    assign fw_op_code_w_execute      = op_p1[10];

    cms_pix_28_rd_mux #(.NUM(NUM_FW), .DATA_W(32)) u_rd_data (
        .clk        (fw_clk),
        .rst        (fw_rst),
        .sel        (dev_id_p1),
        .data_all   (fw_read_data32_all),
        .dflt       ({err, 7'b0, illegal_cnt, cmd_cnt}),
        .rd_data_p2 (sw_read32_0)
    );

    cms_pix_28_rd_mux #(.NUM(NUM_FW), .DATA_W(32)) u_rd_status (
        .clk        (fw_clk),
        .rst        (fw_rst),
        .sel        (dev_id_p1),
        .data_all   (fw_read_status32_all),
        .dflt       (32'h0),
        .rd_data_p2 (sw_read32_1)
    );

endmodule

// File: tb/tb_cms_pix_28_sw_to_fw_decoder.sv
// Directed bench for cms_pix_28_sw_to_fw_decoder with a queue-based scoreboard
// fed by an independent command/counter model.
module tb_cms_pix_28_sw_to_fw_decoder;

    localparam int NUM_FW = 15;

    logic                  fw_clk = 1'b0;
    logic                  fw_rst;
    logic [31:0]           sw_write32_0;
    logic                  sw_write32_0_wr;
    logic [NUM_FW-1:0]     fw_dev_id_enable;
    logic                  op_w_reset, op_w_cs0, op_r_cs0, op_w_ca0, op_r_ca0, op_w_ca1, op_r_ca1;
    logic                  op_r_da0, op_r_da1, op_r_status, op_w_execute;
    logic [23:0]           sw_write24_0;
    logic [32*NUM_FW-1:0]  data_all;
    logic [32*NUM_FW-1:0]  stat_all;
    logic [31:0]           sw_read32_0;
    logic [31:0]           sw_read32_1;
    logic [10:0]           opv;

    always #5 fw_clk = ~fw_clk;

    cms_pix_28_sw_to_fw_decoder #(.NUM_FW(NUM_FW)) dut (
        .fw_clk                    (fw_clk),
        .fw_rst                    (fw_rst),
        .sw_write32_0              (sw_write32_0),
        .sw_write32_0_wr           (sw_write32_0_wr),
        .fw_dev_id_enable          (fw_dev_id_enable),
        .fw_op_code_w_reset        (op_w_reset),
        .fw_op_code_w_cfg_static_0 (op_w_cs0),
        .fw_op_code_r_cfg_static_0 (op_r_cs0),
        .fw_op_code_w_cfg_array_0  (op_w_ca0),
        .fw_op_code_r_cfg_array_0  (op_r_ca0),
        .fw_op_code_w_cfg_array_1  (op_w_ca1),
        .fw_op_code_r_cfg_array_1  (op_r_ca1),
        .fw_op_code_r_data_array_0 (op_r_da0),
        .fw_op_code_r_data_array_1 (op_r_da1),
        .fw_op_code_r_status       (op_r_status),
        .fw_op_code_w_execute      (op_w_execute),
        .sw_write24_0              (sw_write24_0),
        .fw_read_data32_all        (data_all),
        .fw_read_status32_all      (stat_all),
        .sw_read32_0               (sw_read32_0),
        .sw_read32_1               (sw_read32_1)
    );

    // bit k is op-code k+1
    assign opv = {op_w_execute, op_r_status, op_r_da1, op_r_da0, op_r_ca1, op_w_ca1,
                  op_r_ca0, op_w_ca0, op_r_cs0, op_w_cs0, op_w_reset};

    typedef struct packed {
        logic [14:0] en;
        logic [10:0] op;
        logic [23:0] pay;
    } dec_t;

    dec_t        dec_q[$];
    logic [63:0] rd_q[$];
    int          total = 0;
    int          bad   = 0;
    int          m_cnt = 0;
    int          m_ill = 0;
    bit          m_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic dec_t model_dec(input logic [31:0] w);
        dec_t r;
        int   d;
        int   o;
        d = int'(w[31:28]);
        o = int'(w[27:24]);
        r = '0;
        r.pay = w[23:0];
        if (d >= 1 && d <= NUM_FW && o <= 11) begin
            r.en[d-1] = 1'b1;
            if (o != 0) r.op[o-1] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [63:0] model_rd(input logic [31:0] w);
        int          d;
        logic [31:0] ci;
        logic [31:0] cc;
        d  = int'(w[31:28]);
        ci = 32'(m_ill);
        cc = 32'(m_cnt);
        if (d >= 1 && d <= NUM_FW)
            return {data_all[32*(d-1) +: 32], stat_all[32*(d-1) +: 32]};
        return {m_err, 7'b0, ci[7:0], cc[15:0], 32'h0};
    endfunction

    task automatic model_cmd(input logic [31:0] w);
        if (w[31:24] == 8'h0F) begin
            m_cnt = 0;
            m_ill = 0;
            m_err = 1'b0;
        end else begin
            m_cnt = (m_cnt + 1) % 65536;
            if (w[27:24] >= 4'hC) begin
                if (m_ill < 255) m_ill++;
                m_err = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_ill = 0;
        m_err = 1'b0;
    endtask

    // called on the negedge right after the strobe was sampled
    task automatic drain(input string tag);
        dec_t        de;
        logic [63:0] re;
        de = dec_q.pop_front();
        check({tag, "/dec"}, {14'b0, fw_dev_id_enable, opv, sw_write24_0}, {14'b0, de});
        @(negedge fw_clk);
        re = rd_q.pop_front();
        check({tag, "/rd"}, {sw_read32_0, sw_read32_1}, re);
        check({tag, "/hold"}, {14'b0, fw_dev_id_enable, opv, sw_write24_0}, {14'b0, de});
    endtask

    task automatic strobe(input logic [31:0] w, input string tag);
        @(negedge fw_clk);
        sw_write32_0    = w;
        sw_write32_0_wr = 1'b1;
        model_cmd(w);
        dec_q.push_back(model_dec(w));
        rd_q.push_back(model_rd(w));
        @(negedge fw_clk);
        sw_write32_0_wr = 1'b0;
        drain(tag);
    endtask

    task automatic pulse_reset();
        @(negedge fw_clk);
        fw_rst = 1'b1;
        @(negedge fw_clk);
        fw_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fw_rst          = 1'b1;
        sw_write32_0    = '0;
        sw_write32_0_wr = 1'b0;
        for (int i = 0; i < NUM_FW; i++) begin
            data_all[32*i +: 32] = 32'hD000_0000 | 32'(i + 1);
            stat_all[32*i +: 32] = 32'h5000_0000 | 32'(i + 1);
        end
        repeat (3) @(negedge fw_clk);
        check("reset/dec", {14'b0, fw_dev_id_enable, opv, sw_write24_0}, 64'h0);
        check("reset/rd", {sw_read32_0, sw_read32_1}, 64'h0);
        fw_rst = 1'b0;
        model_reset();
        repeat (2) @(negedge fw_clk);
        check("idle/rd", {sw_read32_0, sw_read32_1}, 64'h0);

        strobe(32'h2B00_00AA, "dev2_exec");
        check("dev2_exec/lit", {39'b0, fw_dev_id_enable, op_w_execute, sw_write24_0},
              {39'b0, 15'h0002, 1'b1, 24'h0000AA});
        strobe(32'h0000_0000, "cnt_after_one");

        for (int op = 1; op <= 11; op++)
            strobe({4'h1, 4'(op), 24'h00_1000 | 24'(op)}, $sformatf("dev1_op%0d", op));

        pulse_reset();
        strobe(32'h3D00_0000, "illegal_dev3");
        strobe(32'h0000_0000, "read_err");
        check("read_err/lit", {32'h0, sw_read32_0}, {32'h0, 32'h8001_0002});

        data_all[32*4 +: 32] = 32'hDEAD_BEEF;
        stat_all[32*4 +: 32] = 32'h1234_5678;
        strobe(32'h5800_0055, "dev5_rdata");
        check("dev5_rdata/lit", {sw_read32_0, sw_read32_1}, {32'hDEAD_BEEF, 32'h1234_5678});
        data_all[32*4 +: 32] = 32'hCAFE_F00D;
        @(negedge fw_clk);
        check("dev5_live", {32'h0, sw_read32_0}, {32'h0, 32'hCAFE_F00D});

        strobe(32'hF300_0F0F, "dev15_max");
        strobe(32'h5F00_0001, "dev5_opF_illegal");
        strobe(32'h0E12_3456, "dev0_illegal");

        pulse_reset();
        @(negedge fw_clk);
        sw_write32_0_wr = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sw_write32_0 = 32'h0E00_0000 | 32'(i);
            model_cmd(sw_write32_0);
            if (i == 299) begin
                dec_q.push_back(model_dec(sw_write32_0));
                rd_q.push_back(model_rd(sw_write32_0));
            end
            @(negedge fw_clk);
        end
        sw_write32_0_wr = 1'b0;
        drain("burst300");
        check("burst300/lit", {32'h0, sw_read32_0}, {32'h0, 32'h80FF_012C});
        strobe(32'h0F00_0000, "clear");
        check("clear/lit", {32'h0, sw_read32_0}, 64'h0);

        strobe(32'h7A00_0077, "dev7_status");
        @(posedge fw_clk);
        #2;
        fw_rst = 1'b1;
        #1;
        check("mid_reset/dec", {14'b0, fw_dev_id_enable, opv, sw_write24_0}, 64'h0);
        check("mid_reset/rd", {sw_read32_0, sw_read32_1}, 64'h0);
        @(negedge fw_clk);
        fw_rst = 1'b0;
        model_reset();
        repeat (2) @(negedge fw_clk);
        check("post_reset/rd", {sw_read32_0, sw_read32_1}, 64'h0);
        strobe(32'h2100_0001, "resume");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
